// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine spin controller.
// Bet decode lives here so the priority order is defined once.
package slot_pkg;

    localparam int BAL_W_DEF = 27;
    localparam int BET_W     = 7;

    localparam logic [BET_W-1:0] BET1   = 7'd1;
    localparam logic [BET_W-1:0] BET10  = 7'd10;
    localparam logic [BET_W-1:0] BET50  = 7'd50;
    localparam logic [BET_W-1:0] BET100 = 7'd100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPIN   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_PAYOUT = 2'd3
    } state_t;

    // Lowest denomination wins when several switches are up.
    function automatic logic [BET_W-1:0] bet_decode(input logic b1, input logic b10,
                                                   input logic b50, input logic b100);
        logic [BET_W-1:0] v;
        v = '0;
        if (b1)        v = BET1;
        else if (b10)  v = BET10;
        else if (b50)  v = BET50;
        else if (b100) v = BET100;
        return v;
    endfunction

endpackage

// File: rtl/slot_spin_ctrl_spin_timer.sv
// Loadable down-counter that times the reel-run window.
// Load wins over enable; the count parks at zero.
module spin_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/slot_spin_ctrl.sv
// Spin sequencer: debit the wager, run the reels, evaluate the digits, credit a jackpot.
// state     | meaning
// ST_IDLE   | waiting for a spin edge, balance checked against the selected bet
// ST_SPIN   | reels running for SPIN_CYCLES cycles on the latched bet
// ST_EVAL   | reels frozen, digits compared, payout computed
// ST_PAYOUT | payout credited (saturating), win pulse, last_payout updated
module slot_spin_ctrl
    import slot_pkg::*;
#(
    parameter int INIT_BALANCE = 100,
    parameter int SPIN_CYCLES  = 16,
    parameter int JACKPOT_MULT = 10,
    parameter int BAL_W        = BAL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b1,
    input  logic             b10,
    input  logic             b50,
    input  logic             b100,
    input  logic             spin,
    input  logic [3:0]       reel1,
    input  logic [3:0]       reel2,
    input  logic [3:0]       reel3,
    input  logic [3:0]       reel4,
    output logic             reel_run,
    output logic [BAL_W-1:0] balance,
    output logic             busy,
    output logic             win,
    output logic             reject,
    output logic [BAL_W-1:0] last_payout
);

    localparam int PW    = BAL_W + 4;
    localparam int SW    = PW + 1;
    localparam int CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SPIN_LOAD = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [BAL_W-1:0] BAL_MAX   = '1;

    state_t           state, state_nxt;
    logic             spin_prev;
    logic             req;
    logic [BET_W-1:0] bet;
    logic [BET_W-1:0] bet_q;
    logic [BAL_W-1:0] bet_ext;
    logic             accept;
    logic             refuse;
    logic             match;
    logic             tmr_zero;
    logic [PW-1:0]    product;
    logic [PW-1:0]    pay_q;
    logic [SW-1:0]    sum_full;

    assign bet     = bet_decode(b1, b10, b50, b100);
    assign bet_ext = BAL_W'(bet);
    assign req     = spin && !spin_prev;
    assign refuse  = (state == ST_IDLE) && req && (bet != '0) && (bet_ext > balance);
    assign accept  = (state == ST_IDLE) && req && (bet != '0) && (bet_ext <= balance);
    assign match   = (reel1 == reel2) && (reel2 == reel3) && (reel3 == reel4);

    // Product widened before saturation so large multipliers cannot wrap.
    assign product  = PW'(bet_q) * PW'(JACKPOT_MULT);
    assign sum_full = SW'(balance) + SW'(pay_q);

    spin_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (SPIN_LOAD),
        .en       (state == ST_SPIN),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (accept)   state_nxt = ST_SPIN;
            ST_SPIN:   if (tmr_zero) state_nxt = ST_EVAL;
            ST_EVAL:   state_nxt = ST_PAYOUT;
            ST_PAYOUT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        reel_run = (state == ST_SPIN);
        busy     = (state != ST_IDLE);
        win      = (state == ST_PAYOUT) && (pay_q != '0);
        reject   = refuse;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spin_prev   <= 1'b0;
            balance     <= BAL_W'(INIT_BALANCE);
            bet_q       <= '0;
            pay_q       <= '0;
            last_payout <= '0;
        end else begin
            spin_prev <= spin;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        balance <= balance - bet_ext;
                        bet_q   <= bet;
                    end
                end
                ST_EVAL: begin
                    pay_q <= match ? product : '0;
                end
                ST_PAYOUT: begin
                    balance     <= (sum_full > SW'(BAL_MAX)) ? BAL_MAX : sum_full[BAL_W-1:0];
                    last_payout <= (pay_q > PW'(BAL_MAX)) ? BAL_MAX : pay_q[BAL_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_spin_ctrl.sv
// Bench for slot_spin_ctrl: directed scenarios with literal expectations,
// then randomized play checked every cycle against a spin-timeline model.
module tb_slot_spin_ctrl;

    localparam int     SPIN = 16;
    localparam int     MULT = 10;
    localparam longint BMAX = (longint'(1) << 27) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        b1 = 1'b0, b10 = 1'b0, b50 = 1'b0, b100 = 1'b0;
    logic        spin = 1'b0;
    logic [3:0]  reel1 = '0, reel2 = '0, reel3 = '0, reel4 = '0;
    logic        reel_run, busy, win, reject;
    logic [26:0] balance, last_payout;

    int checks   = 0;
    int failures = 0;

    slot_spin_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .b1          (b1),
        .b10         (b10),
        .b50         (b50),
        .b100        (b100),
        .spin        (spin),
        .reel1       (reel1),
        .reel2       (reel2),
        .reel3       (reel3),
        .reel4       (reel4),
        .reel_run    (reel_run),
        .balance     (balance),
        .busy        (busy),
        .win         (win),
        .reject      (reject),
        .last_payout (last_payout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: a spin is tracked by its age in cycles since acceptance.
    longint m_bal = 100, m_last = 0, m_bet = 0, m_pay = 0, m_b = 0;
    int     age = 0;
    logic   m_prev = 1'b0, m_req = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            m_bal = 100; m_last = 0; m_bet = 0; m_pay = 0; age = 0; m_prev = 1'b0;
        end else begin
            m_b   = b1 ? 1 : (b10 ? 10 : (b50 ? 50 : (b100 ? 100 : 0)));
            m_req = spin && !m_prev;
            chk("mdl_balance",     longint'(balance),     m_bal);
            chk("mdl_last_payout", longint'(last_payout), m_last);
            chk("mdl_reel_run",    longint'(reel_run), (age >= 1 && age <= SPIN) ? 1 : 0);
            chk("mdl_busy",        longint'(busy),     (age != 0) ? 1 : 0);
            chk("mdl_win",         longint'(win),      (age == SPIN + 2 && m_pay != 0) ? 1 : 0);
            chk("mdl_reject",      longint'(reject),
                (age == 0 && m_req && m_b != 0 && m_b > m_bal) ? 1 : 0);
            m_prev = spin;
            if (age == 0) begin
                if (m_req && m_b != 0 && m_b <= m_bal) begin
                    m_bal -= m_b;
                    m_bet  = m_b;
                    age    = 1;
                end
            end else if (age == SPIN + 1) begin
                m_pay = (reel1 == reel2 && reel1 == reel3 && reel1 == reel4) ? m_bet * MULT : 0;
                age++;
            end else if (age == SPIN + 2) begin
                m_bal  = (m_bal + m_pay > BMAX) ? BMAX : m_bal + m_pay;
                m_last = m_pay;
                age    = 0;
            end else begin
                age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reels(input int a, input int b, input int c, input int d);
        reel1 = 4'(a); reel2 = 4'(b); reel3 = 4'(c); reel4 = 4'(d);
    endtask

    task automatic set_bets(input logic s1, input logic s10, input logic s50, input logic s100);
        b1 = s1; b10 = s10; b50 = s50; b100 = s100;
    endtask

    // Caller presents the request in the current cycle; runs until busy drops.
    task automatic run_spin(input logic hold, input int toggle_at, output longint bal1,
                            output int lat, output int runs, output int wins);
        lat = 0; runs = 0; wins = 0; bal1 = 0;
        do begin
            tick();
            lat++;
            if (lat == 1 && !hold) spin = 1'b0;
            if (lat == toggle_at) set_bets(1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            if (lat == 1) bal1 = longint'(balance);
            runs += int'(reel_run);
            wins += int'(win);
        end while (busy && lat < 60);
    endtask

    longint bal1;
    int     lat, runs, wins, extra;

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_balance", longint'(balance), 100);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_balance",  longint'(balance),     100);
        chk("reset_busy",     longint'(busy),        0);
        chk("reset_reel_run", longint'(reel_run),    0);
        chk("reset_last",     longint'(last_payout), 0);

        // jackpot on bet 10
        tick(); set_bets(1'b0, 1'b1, 1'b0, 1'b0); set_reels(7, 7, 7, 7); spin = 1'b1;
        run_spin(1'b0, 0, bal1, lat, runs, wins);
        chk("jack_debit",   bal1, 90);
        chk("jack_latency", lat, 19);
        chk("jack_runs",    runs, 16);
        chk("jack_wins",    wins, 1);
        chk("jack_balance", longint'(balance), 190);
        chk("jack_last",    longint'(last_payout), 100);
        #1 chk("pin_model_jack", m_bal, 190);

        // losses on bet 100 then 50
        tick(); set_bets(1'b0, 1'b0, 1'b0, 1'b1); set_reels(1, 2, 3, 4); spin = 1'b1;
        run_spin(1'b0, 0, bal1, lat, runs, wins);
        chk("loss_debit",   bal1, 90);
        chk("loss_latency", lat, 19);
        chk("loss_runs",    runs, 16);
        chk("loss_wins",    wins, 0);
        chk("loss_balance", longint'(balance), 90);
        chk("loss_last",    longint'(last_payout), 0);
        tick(); set_bets(1'b0, 1'b0, 1'b1, 1'b0); spin = 1'b1;
        run_spin(1'b0, 0, bal1, lat, runs, wins);
        chk("loss50_balance", longint'(balance), 40);
        #1 chk("pin_model_40", m_bal, 40);

        // bet 50 refused at balance 40
        tick(); spin = 1'b1;
        @(negedge clk);
        chk("reject_pulse", longint'(reject), 1);
        chk("reject_busy",  longint'(busy), 0);
        tick(); spin = 1'b0;
        @(negedge clk);
        chk("reject_once",    longint'(reject), 0);
        chk("reject_idle",    longint'(busy), 0);
        chk("reject_balance", longint'(balance), 40);

        // b1 and b50 together: bet 1 wins priority
        tick(); set_bets(1'b1, 1'b0, 1'b1, 1'b0); spin = 1'b1;
        run_spin(1'b0, 0, bal1, lat, runs, wins);
        chk("prio_debit",   bal1, 39);
        chk("prio_balance", longint'(balance), 39);

        // no switch: request ignored
        tick(); set_bets(1'b0, 1'b0, 1'b0, 1'b0); spin = 1'b1;
        @(negedge clk);
        chk("nobet_reject", longint'(reject), 0);
        tick(); spin = 1'b0;
        @(negedge clk);
        chk("nobet_busy",    longint'(busy), 0);
        chk("nobet_balance", longint'(balance), 39);

        // held button: one spin only
        tick(); set_bets(1'b1, 1'b0, 1'b0, 1'b0); spin = 1'b1;
        run_spin(1'b1, 0, bal1, lat, runs, wins);
        extra = 0;
        repeat (21) begin
            tick();
            @(negedge clk);
            extra += int'(busy);
        end
        chk("held_runs",    runs, 16);
        chk("held_extra",   extra, 0);
        chk("held_balance", longint'(balance), 38);

        // switch change mid-spin keeps the latched bet
        tick(); spin = 1'b0;
        tick(); set_bets(1'b0, 1'b1, 1'b0, 1'b0); set_reels(7, 7, 7, 7); spin = 1'b1;
        run_spin(1'b0, 5, bal1, lat, runs, wins);
        chk("toggle_debit",   bal1, 28);
        chk("toggle_balance", longint'(balance), 128);
        chk("toggle_last",    longint'(last_payout), 100);

        // reset in the fifth spin cycle
        tick(); set_bets(1'b0, 1'b1, 1'b0, 1'b0); set_reels(1, 2, 3, 4); spin = 1'b1;
        tick(); spin = 1'b0;
        repeat (4) tick();
        chk("pre_rst_reel_run", longint'(reel_run), 1);
        chk("pre_rst_balance",  longint'(balance), 118);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_balance",  longint'(balance), 100);
        chk("async_rst_reel_run", longint'(reel_run), 0);
        chk("async_rst_busy",     longint'(busy), 0);
        tick(); tick(); rst = 1'b1;

        // balance equal to bet is accepted and empties the balance
        tick(); set_bets(1'b0, 1'b0, 1'b0, 1'b1); spin = 1'b1;
        run_spin(1'b0, 0, bal1, lat, runs, wins);
        chk("eq_debit",   bal1, 0);
        chk("eq_latency", lat, 19);
        chk("eq_balance", longint'(balance), 0);
        tick(); set_bets(1'b1, 1'b0, 1'b0, 1'b0); spin = 1'b1;
        @(negedge clk);
        chk("zero_reject", longint'(reject), 1);
        tick(); spin = 1'b0;
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) spin = ~spin;
            if ($urandom_range(0, 7) == 0) {b100, b50, b10, b1} = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                reel1 = 4'($urandom_range(0, 15));
                reel2 = reel1; reel3 = reel1; reel4 = reel1;
            end else begin
                reel1 = 4'($urandom_range(0, 15)); reel2 = 4'($urandom_range(0, 15));
                reel3 = 4'($urandom_range(0, 15)); reel4 = 4'($urandom_range(0, 15));
            end
        end
        tick(); rst = 1'b1; spin = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
